metrics_counter_bank: RTL

//  Multi-channel performance-counter bank; successor to the single 64-bit metrics counter.
//  Per channel: enable, clear and mode (cycle/event), plus wrap or saturate behaviour.

---
 rtl/metrics_counter_bank.sv | 94 +++++++++
 1 files changed

// File: rtl/metrics_counter_bank.sv
// metrics_counter_bank: multi-channel performance-counter bank with sticky overflow and atomic snapshot
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   en         in   N        per-channel count enable
//   clear      in   N        per-channel synchronous clear (beats en/evt)
//   mode       in   N        0: count cycles, 1: count evt cycles
//   evt        in   N        per-channel event strobe
//   snap       in   1        snapshot request, rising edge captures
//   cnt        out  N*W      live counters, channel i at [i*W +: W]
//   snap_cnt   out  N*W      frozen copy of all counters
//   snap_done  out  1        one-cycle pulse after a capture
//   ovf        out  N        sticky overflow flags
// Optional (macro METRICS_THRESHOLD_EN)
//   thresh     in   N*W      per-channel compare value
//   hit        out  N        sticky compare-match flags
//   irq        out  1        registered OR of hit
//
// The event strobe is named evt because event is a reserved word.
module metrics_counter_bank #(
   parameter int NUM_CNT       = 4,
   parameter int COUNTER_WIDTH = 64,
   parameter int SATURATE      = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_CNT-1:0]               en,
   input  logic [NUM_CNT-1:0]               clear,
   input  logic [NUM_CNT-1:0]               mode,
   input  logic [NUM_CNT-1:0]               evt,
   input  logic                             snap,
   output logic [NUM_CNT*COUNTER_WIDTH-1:0] cnt,
   output logic [NUM_CNT*COUNTER_WIDTH-1:0] snap_cnt,
   output logic                             snap_done,
   output logic [NUM_CNT-1:0]               ovf
`ifdef METRICS_THRESHOLD_EN
   ,
   input  logic [NUM_CNT*COUNTER_WIDTH-1:0] thresh,
   output logic [NUM_CNT-1:0]               hit,
   output logic                             irq
`endif
);
   localparam int W = COUNTER_WIDTH;
   logic [NUM_CNT-1:0]   inc;
   logic [NUM_CNT-1:0]   ovf_d;
   logic [NUM_CNT*W-1:0] cnt_d;
   logic                 snap_q;
   logic                 snap_edge;
`ifdef METRICS_THRESHOLD_EN
   logic [NUM_CNT-1:0]   hit_d;
`endif
   assign inc       = en & ~clear & (~mode | evt);
   assign snap_edge = snap & ~snap_q;
   for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
      logic [W-1:0] c;
      logic [W-1:0] sum;
      assign c   = cnt[i*W +: W];
      // saturating build pins an all-ones counter instead of rolling over
      assign sum = (SATURATE != 0 && &c) ? c : c + 1'b1;
      assign cnt_d[i*W +: W] = clear[i] ? '0 : inc[i] ? sum : c;
      assign ovf_d[i] = ~clear[i] & (ovf[i] | (inc[i] & (&c)));
`ifdef METRICS_THRESHOLD_EN
      assign hit_d[i] = ~clear[i] & (hit[i] | (inc[i] & (sum == thresh[i*W +: W])));
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         snap_cnt  <= '0;
         snap_done <= 1'b0;
         snap_q    <= 1'b0;
         ovf       <= '0;
      end else begin
         cnt       <= cnt_d;
         snap_cnt  <= snap_edge ? cnt : snap_cnt;
         snap_done <= snap_edge;
         snap_q    <= snap;
         ovf       <= ovf_d;
      end
   end
`ifdef METRICS_THRESHOLD_EN
   // irq follows next-state hit so both become visible in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit <= '0;
         irq <= 1'b0;
      end else begin
         hit <= hit_d;
         irq <= |hit_d;
      end
   end
`endif
endmodule
